// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e : FSM state encoding (IDLE, CALC, FIX, DONE), STATE_W bits wide
//   cond_neg    : conditional two's-complement negate on a NEG_W-bit value;
//                 callers cast narrower operands up and truncate the result back.
package div_pkg;

  localparam int STATE_W = 2;
  localparam int NEG_W   = 64;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v,
                                                input logic             en);
    return en ? (~v + {{(NEG_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_i  : partial remainder in (DIV_WIDTH+1 bits, always < divisor)
//   bit_i  : next dividend bit shifted into the partial remainder
//   dvs_i  : divisor magnitude
//   rem_o  : next partial remainder
//   q_o    : quotient bit (1 when the trial subtraction does not borrow)
module div_step #(
  parameter int DIV_WIDTH = 8
) (
  input  logic [DIV_WIDTH:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIV_WIDTH-1:0] dvs_i,
  output logic [DIV_WIDTH:0]   rem_o,
  output logic                 q_o
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] dvs_ext;
  logic [DIV_WIDTH:0] diff;
  logic               no_borrow;

  // rem_i < divisor < 2^DIV_WIDTH, so the shifted value always fits in DIV_WIDTH+1 bits.
  assign shifted   = (rem_i << 1) | {{DIV_WIDTH{1'b0}}, bit_i};
  assign dvs_ext   = {1'b0, dvs_i};
  assign no_borrow = (shifted >= dvs_ext);
  assign diff      = shifted - dvs_ext;
  assign rem_o     = no_borrow ? diff : shifted;
  assign q_o       = no_borrow;

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned integer divider (truncating; remainder takes the
// dividend's sign). Resolves BITS_PER_CYCLE quotient bits per CALC cycle using a
// chain of div_step instances. Divide-by-zero and signed overflow bypass CALC.
// Optional build macro: DIV_EARLY_TERM_EN -- when |in2| > |in1| the CALC phase is
// skipped (q=0, r=in1); results are identical, only latency changes.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready only in IDLE)
//   sign                : 1 = signed operands, 0 = unsigned
//   in1, in2            : dividend, divisor
//   out_valid/out_ready : result handshake (result held until accepted)
//   q, r                : quotient, remainder
//   dz, ovf             : divide-by-zero and signed-overflow flags for the result
module iterative_divider
  import div_pkg::*;
#(
  parameter int DIV_WIDTH      = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign,
  input  logic [DIV_WIDTH-1:0] in1,
  input  logic [DIV_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIV_WIDTH-1:0] q,
  output logic [DIV_WIDTH-1:0] r,
  output logic                 dz,
  output logic                 ovf
);

  localparam int W     = DIV_WIDTH;
  localparam int B     = BITS_PER_CYCLE;
  localparam int N     = DIV_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  div_state_e state_q, state_d;

  // dvd_q starts as |dividend| and is shifted left each cycle while quotient
  // bits enter at the bottom; after N cycles it holds the quotient magnitude.
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     in1_q, in1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             exc_dz_q, exc_dz_d;
  logic             exc_ovf_q, exc_ovf_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     r_q, r_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0] mag1, mag2;
  logic         is_dz, is_ovf;

  assign mag1   = W'(cond_neg(NEG_W'(in1), sign && in1[W-1]));
  assign mag2   = W'(cond_neg(NEG_W'(in2), sign && in2[W-1]));
  assign is_dz  = (in2 == '0);
  assign is_ovf = sign && (in1 == MIN_VAL) && (in2 == '1);

  // Restoring-step chain: step j consumes dividend bit W-1-j this cycle.
  logic [W:0]   chain_rem [0:B];
  logic [B-1:0] qbits;

  assign chain_rem[0] = rem_q;

  for (genvar j = 0; j < B; j++) begin : g_step
    div_step #(.DIV_WIDTH(W)) u_step (
      .rem_i (chain_rem[j]),
      .bit_i (dvd_q[W-1-j]),
      .dvs_i (dvs_q),
      .rem_o (chain_rem[j+1]),
      .q_o   (qbits[B-1-j])
    );
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    in1_d     = in1_q;
    cnt_d     = cnt_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    exc_dz_d  = exc_dz_q;
    exc_ovf_d = exc_ovf_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in1_d     = in1;
          dvd_d     = mag1;
          dvs_d     = mag2;
          rem_d     = '0;
          cnt_d     = CNT_W'(N - 1);
          negq_d    = sign && (in1[W-1] ^ in2[W-1]);
          negr_d    = sign && in1[W-1];
          exc_dz_d  = is_dz;
          exc_ovf_d = is_ovf;
          if (is_dz || is_ovf) begin
            state_d = ST_FIX;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (mag2 > mag1) begin
            // Quotient is zero; the remainder is the dividend magnitude, which
            // FIX re-signs back to in1.
            dvd_d   = '0;
            rem_d   = {1'b0, mag1};
            state_d = ST_FIX;
          end
`endif
          else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        rem_d = chain_rem[B];
        dvd_d = (dvd_q << B) | W'(qbits);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (exc_dz_q) begin
          q_d = '1;
          r_d = in1_q;
        end else if (exc_ovf_q) begin
          q_d = in1_q;
          r_d = '0;
        end else begin
          q_d = W'(cond_neg(NEG_W'(dvd_q), negq_q));
          r_d = W'(cond_neg(NEG_W'(rem_q[W-1:0]), negr_q));
        end
        dz_d    = exc_dz_q;
        ovf_d   = exc_ovf_q;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      in1_q     <= '0;
      cnt_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      exc_dz_q  <= 1'b0;
      exc_ovf_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      in1_q     <= in1_d;
      cnt_q     <= cnt_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      exc_dz_q  <= exc_dz_d;
      exc_ovf_q <= exc_ovf_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

  logic clk = 1'b0;
  logic rst;
  logic sgn;
  logic out_ready;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic vld0, vld1, vld2, vld3;

  logic rdy0, rdy1, rdy2, rdy3;
  logic ov0, ov1, ov2, ov3;
  logic [7:0]  q0, r0, q1, r1, q2, r2;
  logic [15:0] q3, r3;
  logic dz0, dz1, dz2, dz3, of0, of1, of2, of3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iterative_divider #(.DIV_WIDTH(8), .BITS_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst(rst), .in_valid(vld0), .in_ready(rdy0), .sign(sgn),
    .in1(a8), .in2(b8), .out_valid(ov0), .out_ready(out_ready),
    .q(q0), .r(r0), .dz(dz0), .ovf(of0));

  iterative_divider #(.DIV_WIDTH(8), .BITS_PER_CYCLE(2)) u_b2 (
    .clk(clk), .rst(rst), .in_valid(vld1), .in_ready(rdy1), .sign(sgn),
    .in1(a8), .in2(b8), .out_valid(ov1), .out_ready(out_ready),
    .q(q1), .r(r1), .dz(dz1), .ovf(of1));

  iterative_divider #(.DIV_WIDTH(8), .BITS_PER_CYCLE(4)) u_b4 (
    .clk(clk), .rst(rst), .in_valid(vld2), .in_ready(rdy2), .sign(sgn),
    .in1(a8), .in2(b8), .out_valid(ov2), .out_ready(out_ready),
    .q(q2), .r(r2), .dz(dz2), .ovf(of2));

  iterative_divider #(.DIV_WIDTH(16), .BITS_PER_CYCLE(1)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(vld3), .in_ready(rdy3), .sign(sgn),
    .in1(a16), .in2(b16), .out_valid(ov3), .out_ready(out_ready),
    .q(q3), .r(r3), .dz(dz3), .ovf(of3));

  // Observation mux over the four instances.
  logic [1:0]  sel;
  logic        cur_ready, cur_valid, cur_dz, cur_ovf;
  logic [15:0] cur_q, cur_r;

  always_comb begin
    cur_ready = rdy0; cur_valid = ov0; cur_q = {8'h00, q0}; cur_r = {8'h00, r0};
    cur_dz = dz0; cur_ovf = of0;
    case (sel)
      2'd1: begin cur_ready = rdy1; cur_valid = ov1; cur_q = {8'h00, q1}; cur_r = {8'h00, r1};
                  cur_dz = dz1; cur_ovf = of1; end
      2'd2: begin cur_ready = rdy2; cur_valid = ov2; cur_q = {8'h00, q2}; cur_r = {8'h00, r2};
                  cur_dz = dz2; cur_ovf = of2; end
      2'd3: begin cur_ready = rdy3; cur_valid = ov3; cur_q = q3; cur_r = r3;
                  cur_dz = dz3; cur_ovf = of3; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance u and check result plus latency. Latency is the
  // number of rising edges from the accept edge to the edge at which the consumer
  // first samples out_valid high. Returns at the negedge where out_valid is seen.
  task automatic run(input int u, input string tag, input logic s,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eq, input logic [15:0] er,
                     input logic edz, input logic eovf, input int elat);
    int lat;
    @(negedge clk);
    sel = 2'(u);
    sgn = s; a8 = a[7:0]; b8 = b[7:0]; a16 = a; b16 = b;
    vld0 = (u == 0); vld1 = (u == 1); vld2 = (u == 2); vld3 = (u == 3);
    #1;
    chk({tag, "_in_ready"}, {15'd0, cur_ready}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0; vld3 = 1'b0;
    lat = 1;
    while (cur_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, {15'd0, cur_valid}, 16'd1);
    chk({tag, "_q"}, cur_q, eq);
    chk({tag, "_r"}, cur_r, er);
    chk({tag, "_dz"}, {15'd0, cur_dz}, {15'd0, edz});
    chk({tag, "_ovf"}, {15'd0, cur_ovf}, {15'd0, eovf});
    chk({tag, "_lat"}, 16'(lat), 16'(elat));
  endtask

`ifdef DIV_EARLY_TERM_EN
  localparam int LAT_SMALL = 2;
`else
  localparam int LAT_SMALL = 10;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 2'd0; sgn = 1'b0; out_ready = 1'b1;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0; vld3 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_in_ready",  {15'd0, rdy0}, 16'd1);
    chk("rst_out_valid", {15'd0, ov0},  16'd0);
    chk("rst_q",   {8'h00, q0}, 16'h0000);
    chk("rst_r",   {8'h00, r0}, 16'h0000);
    chk("rst_dz",  {15'd0, dz0}, 16'd0);
    chk("rst_ovf", {15'd0, of0}, 16'd0);

    // Signed cases, W=8 B=1 (N=8)
    run(0, "s_26_7",    1'b1, 16'h001A, 16'h0007, 16'h0003, 16'h0005, 1'b0, 1'b0, 10);
    run(0, "s_m26_7",   1'b1, 16'h00E6, 16'h0007, 16'h00FD, 16'h00FB, 1'b0, 1'b0, 10);
    run(0, "s_m26_m7",  1'b1, 16'h00E6, 16'h00F9, 16'h0003, 16'h00FB, 1'b0, 1'b0, 10);
    run(0, "s_m7_26",   1'b1, 16'h00F9, 16'h001A, 16'h0000, 16'h00F9, 1'b0, 1'b0, LAT_SMALL);
    run(0, "s_m128_1",  1'b1, 16'h0080, 16'h0001, 16'h0080, 16'h0000, 1'b0, 1'b0, 10);

    // Unsigned cases
    run(0, "u_240_26",  1'b0, 16'h00F0, 16'h001A, 16'h0009, 16'h0006, 1'b0, 1'b0, 10);
    run(0, "u_26_240",  1'b0, 16'h001A, 16'h00F0, 16'h0000, 16'h001A, 1'b0, 1'b0, LAT_SMALL);
    run(0, "u_128_255", 1'b0, 16'h0080, 16'h00FF, 16'h0000, 16'h0080, 1'b0, 1'b0, LAT_SMALL);

    // Exceptions
    run(0, "u_dz",      1'b0, 16'h0064, 16'h0000, 16'h00FF, 16'h0064, 1'b1, 1'b0, 2);
    run(0, "s_dz",      1'b1, 16'h0064, 16'h0000, 16'h00FF, 16'h0064, 1'b1, 1'b0, 2);
    run(0, "s_ovf",     1'b1, 16'h0080, 16'h00FF, 16'h0080, 16'h0000, 1'b0, 1'b1, 2);

    // Radix variants and wide operand
    run(1, "b2_255_3",  1'b0, 16'h00FF, 16'h0003, 16'h0055, 16'h0000, 1'b0, 1'b0, 6);
    run(2, "b4_255_3",  1'b0, 16'h00FF, 16'h0003, 16'h0055, 16'h0000, 1'b0, 1'b0, 4);
    run(3, "w16_s",     1'b1, 16'h8AD0, 16'h007B, 16'hFF0D, 16'hFF91, 1'b0, 1'b0, 18);

    // Backpressure: result must hold while out_ready is low; a pulsed request
    // during that window must be dropped.
    out_ready = 1'b0;
    run(0, "bp", 1'b0, 16'h00C8, 16'h0009, 16'h0016, 16'h0002, 1'b0, 1'b0, 10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {15'd0, ov0},  16'd1);
      chk("bp_hold_ready", {15'd0, rdy0}, 16'd0);
      chk("bp_hold_q",     {8'h00, q0},   16'h0016);
      chk("bp_hold_r",     {8'h00, r0},   16'h0002);
      chk("bp_hold_dz",    {15'd0, dz0},  16'd0);
      if (i == 1) begin
        vld0 = 1'b1; sgn = 1'b0; a8 = 8'd5; b8 = 8'd1;
      end else begin
        vld0 = 1'b0;
      end
      @(negedge clk);
    end
    vld0 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_valid", {15'd0, ov0},  16'd0);
    chk("bp_drain_ready", {15'd0, rdy0}, 16'd1);
    chk("bp_drain_q",     {8'h00, q0},   16'h0016);
    chk("bp_drain_r",     {8'h00, r0},   16'h0002);
    repeat (14) @(negedge clk);
    chk("bp_no_queue", {15'd0, ov0}, 16'd0);

    // Reset during the third CALC cycle aborts the request.
    @(negedge clk);
    sel = 2'd0; sgn = 1'b0; a8 = 8'd100; b8 = 8'd3; vld0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", {15'd0, rdy0}, 16'd1);
    chk("rst_mid_valid", {15'd0, ov0},  16'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_after_q", {8'h00, q0}, 16'h0000);
    repeat (12) @(negedge clk);
    chk("rst_no_result", {15'd0, ov0}, 16'd0);
    run(0, "u_50_7", 1'b0, 16'h0032, 16'h0007, 16'h0007, 16'h0001, 1'b0, 1'b0, 10);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
